// File: rtl/tile_pkg.sv
// Shared state type, border colours and tile geometry helper for the tile compositor.
package tile_pkg;

   typedef enum logic [1:0] {
      ST_BROWSE,
      ST_ARM,
      ST_FROZEN,
      ST_RELEASE
   } tile_state_t;

   localparam logic [11:0] BORDER_BROWSE = 12'hF00;
   localparam logic [11:0] BORDER_FROZEN = 12'h0F0;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
   } tile_xy_t;

   // Tiles are laid out row-major, COLS per display row.
   function automatic tile_xy_t tile_origin(input int t, input int cols, input int x0,
                                            input int y0, input int x_pitch, input int y_pitch);
      tile_xy_t o;
      o.x = 11'(x0 + (t % cols) * x_pitch);
      o.y = 10'(y0 + (t / cols) * y_pitch);
      return o;
   endfunction

endpackage

// File: rtl/tile_hit.sv
// Combinational hit test: which tile the raster point falls in, its local
// coordinates, and whether it lies on the cursor tile's border band.
module tile_hit
   import tile_pkg::*;
#(
   parameter int N_TILES = 4,
   parameter int COLS    = 3,
   parameter int TILE_W  = 240,
   parameter int TILE_H  = 320,
   parameter int X0      = 50,
   parameter int Y0      = 32,
   parameter int X_PITCH = 340,
   parameter int Y_PITCH = 384,
   parameter int BORDER  = 3
) (
   input  logic [10:0] hcount_i,
   input  logic [9:0]  vcount_i,
   input  logic [2:0]  cursor_i,
   output logic        hit_o,
   output logic [2:0]  tile_o,
   output logic [10:0] local_x_o,
   output logic [9:0]  local_y_o,
   output logic        border_o
);

   logic [N_TILES-1:0] hit_v;
   logic [N_TILES-1:0] edge_v;
   logic [10:0]        lx_v [N_TILES];
   logic [9:0]         ly_v [N_TILES];

   genvar gi;
   generate
      for (gi = 0; gi < N_TILES; gi++) begin : g_tile
         localparam tile_xy_t ORG = tile_origin(gi, COLS, X0, Y0, X_PITCH, Y_PITCH);
         // Local offsets wrap when left/above the origin, so the >= tests guard them.
         assign lx_v[gi]   = hcount_i - ORG.x;
         assign ly_v[gi]   = vcount_i - ORG.y;
         assign hit_v[gi]  = (hcount_i >= ORG.x) && (int'(lx_v[gi]) < TILE_W) &&
                             (vcount_i >= ORG.y) && (int'(ly_v[gi]) < TILE_H);
         assign edge_v[gi] = (int'(lx_v[gi]) < BORDER) || (int'(lx_v[gi]) >= TILE_W - BORDER) ||
                             (int'(ly_v[gi]) < BORDER) || (int'(ly_v[gi]) >= TILE_H - BORDER);
      end
   endgenerate

   // Scan downwards so the lowest-index overlapping tile is assigned last and wins.
   always_comb begin
      hit_o     = 1'b0;
      tile_o    = 3'd0;
      local_x_o = 11'd0;
      local_y_o = 10'd0;
      border_o  = 1'b0;
      for (int t = N_TILES - 1; t >= 0; t--) begin
         if (hit_v[t]) begin
            hit_o     = 1'b1;
            tile_o    = 3'(t);
            local_x_o = lx_v[t];
            local_y_o = ly_v[t];
            border_o  = edge_v[t] && (cursor_i == 3'(t));
         end
      end
   end

endmodule

// File: rtl/tile_compositor.sv
// Multi-tile compositor: shared BRAM address, gray-to-RGB mux with matched
// sync delay, and the browse/freeze FSM that gates tile writes on frame start.
module tile_compositor
   import tile_pkg::*;
#(
   parameter int N_TILES     = 4,
   parameter int COLS        = 3,
   parameter int TILE_W      = 240,
   parameter int TILE_H      = 320,
   parameter int X0          = 50,
   parameter int Y0          = 32,
   parameter int X_PITCH     = 340,
   parameter int Y_PITCH     = 384,
   parameter int PIX_W       = 7,
   parameter int RAM_LATENCY = 2,
   parameter int BORDER      = 3
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [10:0]                hcount_in,
   input  logic [9:0]                 vcount_in,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   input  logic                       blank_in,
   output logic [16:0]                addr_out,
   input  logic [N_TILES*PIX_W-1:0]   tile_pixel_in,
   input  logic                       btn_next_in,
   input  logic                       btn_sel_in,
   output logic [N_TILES-1:0]         we_mask_out,
   output logic [2:0]                 cursor_out,
   output logic                       frozen_out,
   output logic [11:0]                pixel_out,
   output logic                       hsync_out,
   output logic                       vsync_out,
   output logic                       blank_out
);

   localparam int PIPE = RAM_LATENCY + 2;

   typedef struct packed {
      logic       hit;
      logic [2:0] tile;
      logic       border;
   } meta_t;

   tile_state_t        state_q, state_d;
   logic [2:0]         cursor_q, cursor_d;
   logic [N_TILES-1:0] we_mask_q, we_mask_d;

   logic        hit_s, border_s;
   logic [2:0]  tile_s;
   logic [10:0] lx_s;
   logic [9:0]  ly_s;
   logic [16:0] addr_d;

   logic [16:0] addr_q;
   meta_t       meta_q [RAM_LATENCY+1];
   logic [2:0]  sync_q [PIPE];
   logic [11:0] pixel_q, pixel_d;
   logic [PIX_W-1:0] pix_sel;
   logic [3:0]  gray4;
   logic        unused_pix_lsbs;
   logic        frame_start;

   tile_hit #(
      .N_TILES(N_TILES), .COLS(COLS), .TILE_W(TILE_W), .TILE_H(TILE_H),
      .X0(X0), .Y0(Y0), .X_PITCH(X_PITCH), .Y_PITCH(Y_PITCH), .BORDER(BORDER)
   ) u_hit (
      .hcount_i (hcount_in),
      .vcount_i (vcount_in),
      .cursor_i (cursor_q),
      .hit_o    (hit_s),
      .tile_o   (tile_s),
      .local_x_o(lx_s),
      .local_y_o(ly_s),
      .border_o (border_s)
   );

   // Constant multiplier: maps to shift-add or one DSP.
   assign addr_d = 17'(ly_s) * 17'(TILE_W) + 17'(lx_s);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         addr_q  <= 17'd0;
         pixel_q <= 12'd0;
         for (int k = 0; k <= RAM_LATENCY; k++) meta_q[k] <= '0;
         for (int k = 0; k < PIPE; k++)         sync_q[k] <= 3'd0;
      end else begin
         addr_q    <= addr_d;
         meta_q[0] <= '{hit: hit_s, tile: tile_s, border: border_s};
         for (int k = 1; k <= RAM_LATENCY; k++) meta_q[k] <= meta_q[k-1];
         sync_q[0] <= {hsync_in, vsync_in, blank_in};
         for (int k = 1; k < PIPE; k++)         sync_q[k] <= sync_q[k-1];
         pixel_q   <= pixel_d;
      end
   end

   // Output stage: meta_q[RAM_LATENCY] lines up with the BRAM data for the same pixel.
   always_comb begin
      pix_sel = '0;
      for (int t = 0; t < N_TILES; t++) begin
         if (meta_q[RAM_LATENCY].tile == 3'(t)) pix_sel = tile_pixel_in[t*PIX_W +: PIX_W];
      end
   end

   assign gray4           = pix_sel[PIX_W-1 -: 4];
   assign unused_pix_lsbs = ^pix_sel[PIX_W-5:0];

   always_comb begin
      pixel_d = 12'h000;
      if (sync_q[RAM_LATENCY][0]) begin
         pixel_d = 12'h000;
      end else if (meta_q[RAM_LATENCY].border) begin
         pixel_d = (state_q == ST_FROZEN || state_q == ST_RELEASE) ? BORDER_FROZEN : BORDER_BROWSE;
      end else if (meta_q[RAM_LATENCY].hit) begin
         pixel_d = {gray4, gray4, gray4};
      end
   end

   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= ST_BROWSE;
         cursor_q  <= 3'd0;
         we_mask_q <= '1;
      end else begin
         state_q   <= state_d;
         cursor_q  <= cursor_d;
         we_mask_q <= we_mask_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cursor_d  = cursor_q;
      we_mask_d = we_mask_q;
      case (state_q)
         ST_BROWSE: begin
            if (btn_sel_in) begin
               state_d = ST_ARM;
            end else if (btn_next_in) begin
               cursor_d = (cursor_q == 3'(N_TILES - 1)) ? 3'd0 : cursor_q + 3'd1;
            end
         end
         ST_ARM: begin
            if (frame_start) begin
               for (int t = 0; t < N_TILES; t++) begin
                  if (cursor_q == 3'(t)) we_mask_d[t] = 1'b0;
               end
               state_d = ST_FROZEN;
            end
         end
         ST_FROZEN: begin
            if (btn_sel_in) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (frame_start) begin
               we_mask_d = '1;
               state_d   = ST_BROWSE;
            end
         end
         default: state_d = ST_BROWSE;
      endcase
   end

   assign addr_out    = addr_q;
   assign pixel_out   = pixel_q;
   assign hsync_out   = sync_q[PIPE-1][2];
   assign vsync_out   = sync_q[PIPE-1][1];
   assign blank_out   = sync_q[PIPE-1][0];
   assign we_mask_out = we_mask_q;
   assign cursor_out  = cursor_q;
   assign frozen_out  = (state_q == ST_FROZEN);

endmodule
